// File: rtl/rf_op_sequencer_pkg.sv
// rf_seq_pkg: opcodes, FSM states and widths shared by the register-file op sequencer.
package rf_seq_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MOV = 3'd5,
    OP_LI  = 3'd6,
    OP_SLL = 3'd7
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/rf_op_sequencer_if.sv
// rf_op_sequencer_if: valid/ready command channel from a command source to the sequencer.
interface rf_op_sequencer_if;
  import rf_seq_pkg::*;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [REG_ADDR_W-1:0] cmd_rd;
  logic [REG_ADDR_W-1:0] cmd_rs1;
  logic [REG_ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0]     cmd_imm;
  logic [3:0]            cmd_rep;
  modport master (output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_rep, input cmd_ready);
  modport slave (input cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_rep, output cmd_ready);
endinterface

// File: rtl/rf_op_sequencer_alu.sv
// rf_seq_alu: combinational 32-bit micro-op datapath, modulo 2^32, no flags.
module rf_seq_alu
  import rf_seq_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_y
);
  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_MOV:  o_y = i_a;
      OP_LI:   o_y = i_imm;
      default: o_y = i_a << i_b[4:0];
    endcase
  end
endmodule

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: runs one micro-op per command (with repeats) against a 2R/1W regfile.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter bit ZERO_REG_RO = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  rf_op_sequencer_if.slave      cmd,
  input  logic                  i_abort,
  output logic [REG_ADDR_W-1:0] o_rf_raddr1,
  output logic [REG_ADDR_W-1:0] o_rf_raddr2,
  input  logic [DATA_W-1:0]     i_rf_rdata1,
  input  logic [DATA_W-1:0]     i_rf_rdata2,
  output logic [REG_ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0]     o_rf_wdata,
  output logic                  o_rf_wen,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_aborted,
  output logic                  o_err_r0,
  output logic [DATA_W-1:0]     o_result,
  output logic [CNT_W-1:0]      o_op_count
);
  state_e                r_state, w_next;
  logic [2:0]            r_op;
  logic [DATA_W-1:0]     r_imm, r_result, w_alu;
  logic [3:0]            r_rem;
  logic [REG_ADDR_W-1:0] r_raddr1, r_raddr2, r_waddr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_aborted, w_wr_zero, w_write;

  rf_seq_alu u_alu (.i_op(r_op), .i_a(i_rf_rdata1), .i_b(i_rf_rdata2), .i_imm(r_imm), .o_y(w_alu));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_imm     <= '0;
      r_rem     <= '0;
      r_raddr1  <= '0;
      r_raddr2  <= '0;
      r_waddr   <= '0;
      r_result  <= '0;
      r_count   <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_aborted <= i_abort && (r_state != S_IDLE);
      if (r_state == S_IDLE && cmd.cmd_valid) begin
        r_op     <= cmd.cmd_op;
        r_imm    <= cmd.cmd_imm;
        r_rem    <= cmd.cmd_rep;
        r_raddr1 <= cmd.cmd_rs1;
        r_raddr2 <= cmd.cmd_rs2;
        r_waddr  <= cmd.cmd_rd;
      end
      if (r_state == S_READ && !i_abort) r_result <= w_alu;
      if (w_write && r_rem != '0) r_rem <= r_rem - 4'd1;
      if (o_rf_wen && r_count != '1) r_count <= r_count + 1'b1;
    end
  end

  // Abort outranks every non-IDLE transition, including the normal path into DONE.
  always_comb begin
    w_wr_zero = ZERO_REG_RO && (r_waddr == '0);
    w_write   = (r_state == S_WRITE);
    w_next    = (r_state == S_IDLE)  ? (cmd.cmd_valid ? S_READ : S_IDLE) :
                i_abort              ? S_IDLE :
                (r_state == S_READ)  ? S_WRITE :
                (r_state == S_WRITE) ? ((r_rem != '0) ? S_READ : S_DONE) : S_IDLE;
    cmd.cmd_ready = (r_state == S_IDLE);
    o_busy        = (r_state != S_IDLE);
    o_done        = (r_state == S_DONE) && !i_abort;
    o_rf_wen      = w_write && !w_wr_zero;
    o_err_r0      = w_write && w_wr_zero;
  end

  assign o_rf_raddr1 = r_raddr1;
  assign o_rf_raddr2 = r_raddr2;
  assign o_rf_waddr  = r_waddr;
  assign o_rf_wdata  = r_result;
  assign o_result    = r_result;
  assign o_op_count  = r_count;
  assign o_aborted   = r_aborted;
endmodule

// File: tb/tb_rf_op_sequencer.sv
// tb_rf_op_sequencer: table-driven and hand-sequenced checks against a behavioural regfile.
module tb_rf_op_sequencer;
  import rf_seq_pkg::*;
  logic clk = 1'b0, resetn = 1'b0, abort = 1'b0, clr = 1'b1;
  logic [4:0] raddr1, raddr2, waddr;
  logic [31:0] rdata1, rdata2, wdata, result;
  logic wen, busy, done, aborted, err;
  logic [15:0] count;
  logic [31:0] mem [32];

  rf_op_sequencer_if cif ();

  rf_op_sequencer #(.ZERO_REG_RO(1'b1), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .cmd(cif.slave), .i_abort(abort),
    .o_rf_raddr1(raddr1), .o_rf_raddr2(raddr2),
    .i_rf_rdata1(rdata1), .i_rf_rdata2(rdata2),
    .o_rf_waddr(waddr), .o_rf_wdata(wdata), .o_rf_wen(wen),
    .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_err_r0(err),
    .o_result(result), .o_op_count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    else if (wen) mem[waddr] <= wdata;
  end
  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  rep;
    logic [31:0] exp_val;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t v [13];

  int tests = 0, fails = 0;
  int n_wen, done_k, ab_k, rdy_k, err_k;
  logic [31:0] wlog [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm, input logic [3:0] rep,
                     input int abort_k);
    n_wen = 0; done_k = -1; ab_k = -1; rdy_k = -1; err_k = -1;
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_rd = rd; cif.cmd_rs1 = rs1;
    cif.cmd_rs2 = rs2; cif.cmd_imm = imm; cif.cmd_rep = rep;
    #1 chk("ready_in_idle", {31'd0, cif.cmd_ready}, 32'd1);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    for (int k = 1; k <= 40 && rdy_k < 0; k++) begin
      if (k > 1) @(negedge clk);
      abort = (k == abort_k);
      #1;
      if (wen) begin
        if (n_wen < 16) wlog[n_wen] = wdata;
        n_wen++;
      end
      if (done) done_k = k;
      if (aborted) ab_k = k;
      if (err) err_k = k;
      if (cif.cmd_ready) rdy_k = k;
    end
    abort = 1'b0;
    if (rdy_k < 0) chk("timeout_waiting_ready", 32'd0, 32'd1);
  endtask

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_rd = '0; cif.cmd_rs1 = '0;
    cif.cmd_rs2 = '0; cif.cmd_imm = '0; cif.cmd_rep = '0;
    v[0]  = '{OP_LI,  5'd1,  5'd0,  5'd0, 32'd5,  4'd0, 32'd5,          16'd1};
    v[1]  = '{OP_LI,  5'd2,  5'd0,  5'd0, 32'd7,  4'd0, 32'd7,          16'd2};
    v[2]  = '{OP_ADD, 5'd3,  5'd1,  5'd2, 32'd0,  4'd0, 32'd12,         16'd3};
    v[3]  = '{OP_ADD, 5'd1,  5'd1,  5'd2, 32'd0,  4'd2, 32'd26,         16'd6};
    v[4]  = '{OP_LI,  5'd4,  5'd0,  5'd0, 32'd0,  4'd0, 32'd0,          16'd7};
    v[5]  = '{OP_LI,  5'd5,  5'd0,  5'd0, 32'd1,  4'd0, 32'd1,          16'd8};
    v[6]  = '{OP_SUB, 5'd6,  5'd4,  5'd5, 32'd0,  4'd0, 32'hFFFF_FFFF,  16'd9};
    v[7]  = '{OP_LI,  5'd8,  5'd0,  5'd0, 32'd31, 4'd0, 32'd31,         16'd10};
    v[8]  = '{OP_SLL, 5'd7,  5'd5,  5'd8, 32'd0,  4'd0, 32'h8000_0000,  16'd11};
    v[9]  = '{OP_AND, 5'd9,  5'd6,  5'd1, 32'd0,  4'd0, 32'h0000_001A,  16'd12};
    v[10] = '{OP_OR,  5'd10, 5'd7,  5'd5, 32'd0,  4'd0, 32'h8000_0001,  16'd13};
    v[11] = '{OP_XOR, 5'd11, 5'd10, 5'd6, 32'd0,  4'd0, 32'h7FFF_FFFE,  16'd14};
    v[12] = '{OP_MOV, 5'd12, 5'd3,  5'd0, 32'd0,  4'd0, 32'd12,         16'd15};

    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    chk("rst_raddr1", {27'd0, raddr1}, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm, v[i].rep, 0);
      chk($sformatf("v%0d_reg", i), mem[v[i].rd], v[i].exp_val);
      chk($sformatf("v%0d_nwen", i), n_wen, 32'(v[i].rep) + 32'd1);
      chk($sformatf("v%0d_done_k", i), done_k, 2 * (32'(v[i].rep) + 32'd1) + 32'd1);
      chk($sformatf("v%0d_ready_k", i), rdy_k, 2 * (32'(v[i].rep) + 32'd1) + 32'd2);
      chk($sformatf("v%0d_no_abort", i), ab_k, -1);
      chk($sformatf("v%0d_count", i), {16'd0, count}, {16'd0, v[i].exp_cnt});
      if (i == 3) begin
        chk("acc_w0", wlog[0], 32'd12);
        chk("acc_w1", wlog[1], 32'd19);
        chk("acc_w2", wlog[2], 32'd26);
      end
    end

    run(OP_LI, 5'd0, 5'd0, 5'd0, 32'h1234, 4'd0, 0);
    chk("r0_nwen", n_wen, 0);
    chk("r0_err_k", err_k, 2);
    chk("r0_done_k", done_k, 3);
    chk("r0_count", {16'd0, count}, 32'd15);
    chk("r0_value", mem[0], 32'd0);

    run(OP_LI, 5'd1, 5'd0, 5'd0, 32'd5, 4'd0, 0);
    run(OP_ADD, 5'd1, 5'd1, 5'd2, 32'd0, 4'd15, 5);
    chk("abort_nwen", n_wen, 2);
    chk("abort_r1", mem[1], 32'd19);
    chk("abort_pulse_k", ab_k, 6);
    chk("abort_no_done", done_k, -1);
    chk("abort_ready_k", rdy_k, 6);
    chk("abort_count", {16'd0, count}, 32'd18);

    run(OP_LI, 5'd14, 5'd0, 5'd0, 32'd9, 4'd0, 3);
    chk("abort_done_nodone", done_k, -1);
    chk("abort_done_pulse_k", ab_k, 4);
    chk("abort_done_r14", mem[14], 32'd9);
    chk("abort_done_count", {16'd0, count}, 32'd19);

    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = OP_ADD; cif.cmd_rd = 5'd13;
    cif.cmd_rs1 = 5'd1; cif.cmd_rs2 = 5'd2; cif.cmd_rep = 4'd0;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    #1 chk("mid_busy_read", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
    chk("mid_rst_raddr1", {27'd0, raddr1}, 32'd0);
    chk("mid_rst_wdata", wdata, 32'd0);
    chk("mid_rst_count", {16'd0, count}, 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_nowen", {31'd0, wen}, 32'd0);
    chk("mid_rst_r13", mem[13], 32'd0);
    resetn = 1'b1;
    run(OP_ADD, 5'd13, 5'd1, 5'd2, 32'd0, 4'd0, 0);
    chk("post_rst_r13", mem[13], 32'd26);
    chk("post_rst_done_k", done_k, 3);
    chk("post_rst_count", {16'd0, count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_op_sequencer.md
Name: rf_op_sequencer

Overview:
Command-driven controller for the 2-read/1-write 32x32 register file. It accepts one micro-op per valid/ready handshake, drives the regfile read and write ports, computes the result, and writes it back. Each command can repeat up to 16 times, with each iteration re-reading the register file. It sits between the register file and any command source (touchscreen input logic or a scripted test driver), replacing ad-hoc "sum" style hooks.

Parameters:
ZERO_REG_RO, 1, when 1, writes to r0 are suppressed (rf_wen stays low) and err_r0 pulses.
CNT_W, 16, width of the completed-write counter op_count.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  opcode (see package)
cmd_rd  in  5  destination register
cmd_rs1  in  5  source register 1
cmd_rs2  in  5  source register 2
cmd_imm  in  32  immediate for LI
cmd_rep  in  4  extra iterations (0 = run once)
abort  in  1  cancel the current command
rf_raddr1  out  5  to regfile raddr1
rf_raddr2  out  5  to regfile raddr2
rf_rdata1  in  32  from regfile, combinational read
rf_rdata2  in  32  from regfile, combinational read
rf_waddr  out  5  to regfile waddr
rf_wdata  out  32  to regfile wdata
rf_wen  out  1  to regfile wen
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at normal completion
aborted  out  1  one-cycle pulse after abort
err_r0  out  1  one-cycle pulse, in the WRITE cycle, when a write to r0 is suppressed
result  out  32  last computed value, held until the next write
op_count  out  CNT_W  saturating count of writes actually performed

Behaviour:
- Reset (resetn=0 at posedge): state IDLE. All registered outputs are 0: addresses, wdata, result, op_count, and the pulses. Reset mid-command discards the command without writing, unless the reset edge coincides with the WRITE-cycle edge, in which case the regfile write still occurs (rf_wen is state-decoded).
- States: IDLE, READ, WRITE, DONE.
- IDLE: cmd_ready=1. When cmd_valid=1, latch op, rd, rs1, rs2, imm, and rep into rem_cnt, then go to READ. The handshake cycle is T.
- READ (1 cycle): rf_raddr1=rs1, rf_raddr2=rs2, both stable from T+1. At the end of the cycle, register alu(op, rf_rdata1, rf_rdata2, imm) into result/rf_wdata. Next state is WRITE.
- WRITE (1 cycle): rf_waddr=rd, rf_wdata=result. rf_wen=1 unless (ZERO_REG_RO && rd==0). op_count increments, saturating at all-ones, only if the write occurs.
  - If rem_cnt!=0: decrement rem_cnt and go to READ. The next READ sees the value just written.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- Latency: done is high in cycle T+2*(rep+1)+1. A new command can be accepted in the cycle after DONE. Back-to-back throughput is 2*(rep+1)+2 cycles per command.
- Opcodes and arithmetic: all 32-bit modulo 2^32, no flags.
  - ADD: a+b
  - SUB: a-b (wraps)
  - AND, OR, XOR: bitwise
  - MOV: a
  - LI: imm (read data ignored)
  - SLL: a << b[4:0]
- Abort:
  - Sampled in READ, WRITE or DONE. The next state is IDLE, aborted pulses in the next cycle, and done is not asserted.
  - A WRITE cycle coinciding with abort still writes.
  - Abort in IDLE is ignored.
  - If abort and the normal DONE transition coincide, abort wins: aborted=1, done=0.
- cmd_valid while busy: ignored. cmd_ready=0, no queueing, and the source must hold the command.
- rd==rs1 with repeat: this is accumulation, e.g. ADD r1,r1,r2, rep=n gives r1 += (n+1)*r2.

Decomposition:
- Shared package rf_seq_pkg holds:
  - opcode constants: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_MOV=5, OP_LI=6, OP_SLL=7
  - state encodings: S_IDLE=0, S_READ=1, S_WRITE=2, S_DONE=3
  - REG_ADDR_W=5, DATA_W=32
- One combinational sub-module, rf_seq_alu (op, a, b, imm -> y), instantiated once. The FSM, counters and pulses stay in rf_op_sequencer.

Test Plan:
1. LI r1,5; LI r2,7; ADD r3,r1,r2, rep=0 -> r3=12. rf_wen high exactly 1 cycle per command, at T+2. done at T+3. op_count=3.
2. With r1=5, r2=7: ADD r1,r1,r2, rep=2 -> three WRITE cycles with wdata 12, 19, 26. Final r1=26. done at T+7. cmd_ready low T+1..T+7.
3. LI r4,0; LI r5,1; SUB r6,r4,r5 -> r6=0xFFFFFFFF. Then SLL r7,r5,r8 with r8=31 -> r7=0x80000000.
4. ZERO_REG_RO=1: LI r0,0x1234 -> rf_wen never high, err_r0 pulses at T+2, done at T+3, op_count unchanged, r0 unchanged.
5. ADD r1,r1,r2, rep=15 with abort asserted in the 3rd READ -> exactly 2 writes (r1=19 from 5/7), aborted pulse, no done, cmd_ready=1 the following cycle.
6. resetn=0 during READ of an ADD -> no write, all outputs 0, state IDLE. A command issued after reset release completes normally.
